pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage integer core. It resolves stall requests from IF/ID/EX/MEM into the 6-bit stall vector used by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb). It sequences exception/ERET redirection: it freezes the pipe for one cycle, then issues a one-cycle flush with the registered redirect PC. It also keeps stall-cycle statistics and a sticky stall-timeout flag for debug.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_exc_vector_dec.sv | 26 ++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared codes for the pipeline controller: reset/stop levels, stall vectors,
// exception codes and FSM states.
package pipe_ctrl_pkg;

   localparam logic        RstEnable = 1'b1;
   localparam logic        Stop      = 1'b1;
   localparam logic        NoStop    = 1'b0;
   localparam logic [31:0] ZeroWord  = 32'h0000_0000;

   // bit 0 = pc ... bit 5 = wb; a higher requester freezes every earlier stage
   localparam logic [5:0] StallNone = 6'b000000;
   localparam logic [5:0] StallIf   = 6'b000011;
   localparam logic [5:0] StallId   = 6'b000111;
   localparam logic [5:0] StallEx   = 6'b001111;
   localparam logic [5:0] StallMem  = 6'b011111;
   localparam logic [5:0] StallAll  = 6'b111111;

   localparam logic [31:0] ExcInt     = 32'h0000_0001;
   localparam logic [31:0] ExcSyscall = 32'h0000_0008;
   localparam logic [31:0] ExcInvalid = 32'h0000_000a;
   localparam logic [31:0] ExcOv      = 32'h0000_000c;
   localparam logic [31:0] ExcTrap    = 32'h0000_000d;
   localparam logic [31:0] ExcEret    = 32'h0000_000e;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PEND  = 2'd1,
      FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_ctrl_exc_vector_dec.sv
// Maps an exception code (and EPC for ERET) to the redirect address.
// Purely combinational so CP0 trace checks can share it.
module exc_vector_dec
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
   parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
   input  logic [31:0] excepttype,
   input  logic [31:0] epc,
   output logic [31:0] vector
);

   always_comb begin
      // NOTE: default assigned first so no path through the case leaves vector unassigned (no latch).
      vector = EXC_VECTOR;
      case (excepttype)
         ExcInt:                                   vector = INT_VECTOR;
         ExcSyscall, 32'h9, ExcInvalid, 32'hb,
         ExcOv, ExcTrap:                           vector = EXC_VECTOR;
         ExcEret:                                  vector = epc;
         default:                                  vector = EXC_VECTOR;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall priority, exception freeze/flush sequencing,
// and stall statistics with a sticky timeout flag.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
   parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
   parameter int          TIMEOUT    = 1024,
   parameter int          CNT_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_if,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic        exc_valid,
   input  logic [31:0] excepttype,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout,
   output logic [31:0] stall_cycles
);

   state_e             state_q, state_d;
   logic [31:0]        exc_type_q, exc_type_d;
   logic [31:0]        epc_q, epc_d;
   logic [31:0]        vec_q, vec_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               timeout_q, timeout_d;
   logic [31:0]        stall_cycles_q, stall_cycles_d;
   logic [31:0]        dec_type, dec_epc, dec_vec;
   logic               stall_active;

   // A deferred exception decodes from what was captured when it was raised.
   assign dec_type = (state_q == PEND) ? exc_type_q : excepttype;
   assign dec_epc  = (state_q == PEND) ? epc_q      : cp0_epc;

   exc_vector_dec #(
      .EXC_VECTOR (EXC_VECTOR),
      .INT_VECTOR (INT_VECTOR)
   ) u_dec (
      .excepttype (dec_type),
      .epc        (dec_epc),
      .vector     (dec_vec)
   );

   always_comb begin
      state_d    = state_q;
      exc_type_d = exc_type_q;
      epc_d      = epc_q;
      vec_d      = vec_q;
      stall      = StallNone;
      flush      = NoStop;
      case (state_q)
         RUN: begin
            if (exc_valid) begin
               if (stallreq_from_mem) begin
                  stall      = StallMem;
                  exc_type_d = excepttype;
                  epc_d      = cp0_epc;
                  state_d    = PEND;
               end else begin
                  stall   = StallAll;
                  vec_d   = dec_vec;
                  state_d = FLUSH;
               end
            end else if (stallreq_from_mem) stall = StallMem;
            else if (stallreq_from_ex)      stall = StallEx;
            else if (stallreq_from_id)      stall = StallId;
            else if (stallreq_from_if)      stall = StallIf;
         end
         PEND: begin
            if (stallreq_from_mem) begin
               stall = StallMem;
            end else begin
               stall   = StallAll;
               vec_d   = dec_vec;
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            flush   = Stop;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      // Outputs are forced quiet while reset is asserted.
      if (rst == RstEnable) begin
         stall = StallNone;
         flush = NoStop;
      end
   end

   always_comb begin
      stall_active   = (stall != StallNone);
      stall_cycles_d = stall_cycles_q + (stall_active ? 32'd1 : 32'd0);
      cnt_d          = cnt_q;
      if (!stall_active || flush)
         cnt_d = '0;
      else if (cnt_q != '1)
         cnt_d = cnt_q + CNT_W'(1);
      timeout_d = timeout_q;
      if (stall_active && (32'(cnt_q) == 32'(TIMEOUT - 1)))
         timeout_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst == RstEnable) begin
         state_q        <= RUN;
         exc_type_q     <= ZeroWord;
         epc_q          <= ZeroWord;
         vec_q          <= ZeroWord;
         cnt_q          <= '0;
         timeout_q      <= 1'b0;
         stall_cycles_q <= ZeroWord;
      end else begin
         state_q        <= state_d;
         exc_type_q     <= exc_type_d;
         epc_q          <= epc_d;
         vec_q          <= vec_d;
         cnt_q          <= cnt_d;
         timeout_q      <= timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign new_pc        = vec_q;
   assign stall_timeout = timeout_q;
   assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a rule-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_pipe_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_if, req_id, req_ex, req_mem;
   logic        exc_valid;
   logic [31:0] excepttype, cp0_epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;
   logic [31:0] stall_cycles;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .EXC_VECTOR (32'h0000_0040),
      .INT_VECTOR (32'h0000_0020),
      .TIMEOUT    (TO),
      .CNT_W      (16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stallreq_from_if  (req_if),
      .stallreq_from_id  (req_id),
      .stallreq_from_ex  (req_ex),
      .stallreq_from_mem (req_mem),
      .exc_valid         (exc_valid),
      .excepttype        (excepttype),
      .cp0_epc           (cp0_epc),
      .stall             (stall),
      .flush             (flush),
      .new_pc            (new_pc),
      .stall_timeout     (stall_timeout),
      .stall_cycles      (stall_cycles)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { logic [31:0] code; logic [31:0] epc; } exc_t;
   exc_t        pend[$];
   bit          m_flush_due = 1'b0;
   logic [31:0] m_vec       = 32'h0;
   logic [31:0] m_cycles    = 32'h0;
   int          m_run       = 0;
   bit          m_timeout   = 1'b0;

   function automatic logic [31:0] target(input logic [31:0] code, input logic [31:0] epc);
      if (code == 32'h1)      return 32'h0000_0020;
      else if (code == 32'he) return epc;
      else                    return 32'h0000_0040;
   endfunction

   always @(negedge clk) begin
      logic [5:0] e_stall;
      logic       e_flush;
      if (chk_en) begin
         e_flush = 1'b0;
         if (rst)                 e_stall = 6'b000000;
         else if (m_flush_due)    begin e_stall = 6'b000000; e_flush = 1'b1; end
         else if (pend.size() > 0 || exc_valid)
                                  e_stall = req_mem ? 6'b011111 : 6'b111111;
         else if (req_mem)        e_stall = 6'b011111;
         else if (req_ex)         e_stall = 6'b001111;
         else if (req_id)         e_stall = 6'b000111;
         else if (req_if)         e_stall = 6'b000011;
         else                     e_stall = 6'b000000;

         check("model_stall", 32'(stall), 32'(e_stall));
         check("model_flush", 32'(flush), 32'(e_flush));
         if (e_flush) check("model_new_pc", new_pc, m_vec);
         check("model_stall_cycles", stall_cycles, m_cycles);
         check("model_timeout", 32'(stall_timeout), 32'(m_timeout));

         if (rst) begin
            pend.delete();
            m_flush_due = 1'b0;
            m_vec       = 32'h0;
            m_cycles    = 32'h0;
            m_run       = 0;
            m_timeout   = 1'b0;
         end else begin
            if (e_stall != 6'b0) begin
               m_cycles = m_cycles + 32'd1;
               if (m_run + 1 >= TO) m_timeout = 1'b1;
            end
            m_run = (e_stall != 6'b0 && !e_flush) ? m_run + 1 : 0;
            if (m_flush_due) begin
               m_flush_due = 1'b0;
            end else if (pend.size() > 0) begin
               if (!req_mem) begin
                  m_vec       = target(pend[0].code, pend[0].epc);
                  m_flush_due = 1'b1;
                  void'(pend.pop_front());
               end
            end else if (exc_valid) begin
               if (req_mem) pend.push_back('{excepttype, cp0_epc});
               else begin
                  m_vec       = target(excepttype, cp0_epc);
                  m_flush_due = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // Drives one cycle of inputs just after the edge, then settles for literal checks.
   task automatic drive(input logic r, input logic i_if, input logic i_id, input logic i_ex,
                        input logic i_mem, input logic ev, input logic [31:0] et,
                        input logic [31:0] epc);
      @(posedge clk);
      #1;
      rst = r; req_if = i_if; req_id = i_id; req_ex = i_ex; req_mem = i_mem;
      exc_valid = ev; excepttype = et; cp0_epc = epc;
      #2;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
      exc_valid = 0; excepttype = 32'h0; cp0_epc = 32'h0;
      @(posedge clk);
      #1 chk_en = 1'b1;

      // reset state
      idle();
      check("reset_stall", 32'(stall), 32'h0);
      check("reset_flush", 32'(flush), 32'h0);
      check("reset_new_pc", new_pc, 32'h0);
      check("reset_timeout", 32'(stall_timeout), 32'h0);
      check("reset_stall_cycles", stall_cycles, 32'h0);

      // priority
      drive(0, 0, 1, 1, 0, 0, 32'h0, 32'h0);
      check("prio_id_ex", 32'(stall), 32'h0f);
      drive(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
      check("prio_if", 32'(stall), 32'h03);
      idle();
      check("prio_none", 32'(stall), 32'h00);
      check("prio_none_flush", 32'(flush), 32'h0);
      drive(0, 1, 1, 1, 1, 0, 32'h0, 32'h0);
      check("prio_all_req", 32'(stall), 32'h1f);

      // syscall
      drive(0, 0, 0, 0, 0, 1, 32'h8, 32'h0);
      check("sys_freeze", 32'(stall), 32'h3f);
      check("sys_freeze_flush", 32'(flush), 32'h0);
      idle();
      check("sys_flush", 32'(flush), 32'h1);
      check("sys_new_pc", new_pc, 32'h40);
      check("sys_flush_stall", 32'(stall), 32'h0);
      idle();
      check("sys_after", 32'(flush), 32'h0);

      // ERET while mem busy; EPC must be the value from the raising cycle
      drive(0, 0, 0, 0, 1, 1, 32'he, 32'h8000_1234);
      check("eret_pend1", 32'(stall), 32'h1f);
      drive(0, 0, 0, 0, 1, 0, 32'h0, 32'hdead_beef);
      check("eret_pend2", 32'(stall), 32'h1f);
      drive(0, 0, 0, 0, 1, 1, 32'h1, 32'hdead_beef);
      check("eret_pend3", 32'(stall), 32'h1f);
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'hdead_beef);
      check("eret_freeze", 32'(stall), 32'h3f);
      idle();
      check("eret_flush", 32'(flush), 32'h1);
      check("eret_new_pc", new_pc, 32'h8000_1234);
      idle();
      check("eret_after", 32'(flush), 32'h0);

      // interrupt, then a second exception raised in the flush cycle
      drive(0, 0, 0, 0, 0, 1, 32'h1, 32'h0);
      check("int_freeze", 32'(stall), 32'h3f);
      drive(0, 0, 1, 0, 1, 1, 32'hc, 32'h0);
      check("int_flush", 32'(flush), 32'h1);
      check("int_new_pc", new_pc, 32'h20);
      check("int_flush_stall", 32'(stall), 32'h0);
      idle();
      check("int_ignored_flush", 32'(flush), 32'h0);
      check("int_ignored_stall", 32'(stall), 32'h0);
      idle();
      check("int_ignored_flush2", 32'(flush), 32'h0);

      // unlisted code falls back to the exception vector
      drive(0, 0, 0, 0, 0, 1, 32'h55, 32'h0);
      idle();
      check("other_new_pc", new_pc, 32'h40);

      // reset while PEND
      drive(0, 0, 0, 0, 1, 1, 32'h8, 32'h0);
      check("rstp_pend", 32'(stall), 32'h1f);
      drive(1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
      check("rstp_in_reset_stall", 32'(stall), 32'h0);
      check("rstp_in_reset_flush", 32'(flush), 32'h0);
      drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
      check("rstp_cycles", stall_cycles, 32'h0);
      check("rstp_new_pc", new_pc, 32'h0);
      check("rstp_mem_only", 32'(stall), 32'h1f);
      idle();
      check("rstp_no_freeze", 32'(stall), 32'h0);
      check("rstp_no_flush", 32'(flush), 32'h0);
      idle();
      check("rstp_no_flush2", 32'(flush), 32'h0);

      // timeout
      drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      for (int k = 0; k < TO; k++) begin
         drive(0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
         check("to_not_yet", 32'(stall_timeout), 32'h0);
      end
      idle();
      check("to_set", 32'(stall_timeout), 32'h1);
      check("to_cycles", stall_cycles, 32'd8);
      drive(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
      idle();
      check("to_sticky", 32'(stall_timeout), 32'h1);
      check("to_cycles_after", stall_cycles, 32'd9);

      idle();
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
